// File: rtl/operand_stack.sv
// LIFO operand stack for the calculator datapath: DEPTH entries of WIDTH bits, one opcode per clock.
// Optional OPERAND_STACK_STICKY_ERR_EN makes Err sticky until CLEAR; otherwise Err is a one-cycle pulse.
module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [2:0]       Sel,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Out2,
  output logic [CW-1:0]    Count,
  output logic             Full,
  output logic             Empty,
  output logic             Err
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSH  = 3'b001,
    OP_LOAD  = 3'b010,
    OP_POP   = 3'b011,
    OP_CLEAR = 3'b100,
    OP_SWAP  = 3'b101,
    OP_DUP   = 3'b110,
    OP_NOP2  = 3'b111
  } op_t;

  op_t              op;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q, count_nxt;
  logic             err_q, err_nxt, illegal;
  logic             empty, full;
  logic [AW-1:0]    top_idx, sec_idx, push_idx, wr_idx;
  logic [WIDTH-1:0] top_val, sec_val, wr_data;
  logic             wr_en, swap_en;

  assign op       = op_t'(Sel);
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign top_idx  = AW'(count_q - CW'(1));
  assign sec_idx  = AW'(count_q - CW'(2));
  assign push_idx = AW'(count_q);
  assign top_val  = mem[top_idx];
  assign sec_val  = mem[sec_idx];

  always_comb begin
    count_nxt = count_q;
    illegal   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = push_idx;
    wr_data   = A;
    swap_en   = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          illegal = 1'b1;
        end else begin
          wr_en     = 1'b1;
          count_nxt = count_q + CW'(1);
        end
      end
      OP_LOAD: begin
        // Legacy load overwrites the top; on an empty stack it behaves as a push.
        wr_en = 1'b1;
        if (empty) begin
          count_nxt = CW'(1);
        end else begin
          wr_idx = top_idx;
        end
      end
      OP_POP: begin
        if (empty) illegal = 1'b1;
        else       count_nxt = count_q - CW'(1);
      end
      OP_CLEAR: count_nxt = '0;
      OP_SWAP: begin
        if (count_q >= CW'(2)) swap_en = 1'b1;
        else                   illegal = 1'b1;
      end
      OP_DUP: begin
        if (empty || full) begin
          illegal = 1'b1;
        end else begin
          wr_en     = 1'b1;
          wr_data   = top_val;
          count_nxt = count_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

`ifdef OPERAND_STACK_STICKY_ERR_EN
  assign err_nxt = (op == OP_CLEAR) ? 1'b0 : (err_q | illegal);
`else
  assign err_nxt = illegal;
`endif

  // Storage carries no reset; stale entries are hidden by the output masks.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end else if (swap_en) begin
      mem[top_idx] <= sec_val;
      mem[sec_idx] <= top_val;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      err_q   <= err_nxt;
    end
  end

  assign Out   = empty ? '0 : top_val;
  assign Out2  = (count_q < CW'(2)) ? '0 : sec_val;
  assign Count = count_q;
  assign Full  = full;
  assign Empty = empty;
  assign Err   = err_q;

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Parametrised successor to the calculator's single 8-bit operand holder.
- Holds up to DEPTH operands of WIDTH bits in LIFO order.
- Executes a 3-bit Sel opcode each clock. Opcodes 010 (load) and 100 (clear) keep their legacy meaning.
- Sits between the keypad/ALU result bus (A) and the ALU operand inputs (Out = top of stack, Out2 = second entry).

Parameters:
- WIDTH, 8: operand width in bits.
- DEPTH, 4: number of stack entries; legal range 2..16.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand data in.
- Sel  input  3  opcode, sampled every rising edge.
- Out  output  WIDTH  top entry; 0 when empty.
- Out2  output  WIDTH  second entry; 0 when count < 2.
- Count  output  CW  entries held, 0..DEPTH; CW = clog2(DEPTH+1).
- Full  output  1  Count == DEPTH.
- Empty  output  1  Count == 0.
- Err  output  1  illegal-operation indication (see Optional Feature).

Behaviour:
- State:
  - storage mem[0..DEPTH-1]; entry 0 is the bottom.
  - counter Count.
  - top = mem[Count-1], second = mem[Count-2].
- Opcodes are decoded on each rising clock edge. The effect is visible on Out, Out2 and Count immediately after that edge (one-edge latency). No handshake: one op per cycle, every cycle.
- Full and Empty are combinational from Count. Out and Out2 are functions of registered state only, so they have no combinational path from A or Sel.
- Opcodes:
  - 000 NOP: no change.
  - 001 PUSH:
    - Count < DEPTH: mem[Count] <= A, Count+1.
    - Full: error, no change.
  - 010 LOAD:
    - Count >= 1: top <= A, Count unchanged.
    - Empty: acts as PUSH, so Count becomes 1.
  - 011 POP:
    - Count >= 1: Count-1; the popped data is not cleared.
    - Empty: error.
  - 100 CLEAR: Count <= 0. Never an error.
  - 101 SWAP:
    - Count >= 2: top and second exchanged in one edge.
    - Otherwise: error.
  - 110 DUP:
    - 1 <= Count < DEPTH: mem[Count] <= top, Count+1.
    - Otherwise: error.
  - 111 NOP: no change.
- Error rule: an illegal op leaves mem and Count completely unchanged. The error event is registered, so it is seen on Err after the same edge.
- Width rules: A is stored unmodified; there is no arithmetic on data. Count never wraps: no increment past DEPTH, no decrement below 0.
- Output masking: Out reads 0 whenever Empty, and Out2 reads 0 whenever Count < 2, regardless of stale mem contents.
- Reset:
  - Asserting reset at any time, including mid-sequence, forces Count = 0 and Err = 0 asynchronously.
  - Out, Out2 = 0 through masking; Empty = 1, Full = 0.
  - mem contents need not be cleared.
  - The first edge after deassertion executes Sel normally.
- Sel values with X/Z are outside the contract; no defined behaviour is required.

Optional Feature:
- Macro: OPERAND_STACK_STICKY_ERR_EN.
- Defined:
  - Err is sticky. It sets on the first illegal op and holds.
  - It clears only on CLEAR (100) or on reset.
  - CLEAR in the same edge as no other event clears it. CLEAR itself is never illegal.
- Undefined: Err is a one-cycle pulse, high for exactly the cycle after each illegal-op edge and low otherwise.

Test Plan (WIDTH=8, DEPTH=4):
- Reset then idle: assert reset mid-run after 3 pushes -> immediately Count=0, Out=0, Out2=0, Empty=1, Err=0; NOP for 5 cycles -> unchanged.
- PUSH 0x11, 0x22, 0x33, 0x44, then PUSH 0x55 -> Count=4, Full=1, Out=0x44, Out2=0x33, Err asserted, 0x55 not stored.
- LOAD 0xA5 on empty -> Count=1, Out=0xA5, Out2=0; LOAD 0x5A -> Count=1, Out=0x5A.
- Push 0x01, 0x02; SWAP -> Out=0x01, Out2=0x02; DUP -> Count=3, Out=0x01, Out2=0x01.
- POP x3 from Count=3 -> Count 2,1,0 with Out=0x01,0x02,0; fourth POP -> Err, Count stays 0.
- Error mode check: illegal POP then NOP x2 -> Err high 1 cycle (macro undefined) or held high until CLEAR (macro defined); CLEAR -> Count=0 and Err=0.
